dual_slope_ctrl: RTL and testbench

Sequencer for the voltmeter's dual-slope integrating ADC. It sits directly upstream of the phase-timing down-counter. It drives the counter's enable and load value to time the auto-zero and integrate phases, consumes the counter's busy/done outputs, and then measures the de-integrate phase itself. It owns the analog switch controls and delivers a 16-bit conversion result with a one-cycle valid pulse.

---
 rtl/voltmeter_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/dual_slope_ctrl.sv | 131 +++++++++++++
 tb/tb_dual_slope_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter: conversion widths, default phase
// lengths and the dual-slope sequencer state encoding.
package voltmeter_pkg;

    localparam int          VM_CNT_W     = 16;
    localparam logic [15:0] VM_T_AZ      = 16'd255;
    localparam logic [15:0] VM_MAX_DEINT = 16'hFFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_AZ    = 3'd1;
    localparam state_t ST_BBM1  = 3'd2;
    localparam state_t ST_INT   = 3'd3;
    localparam state_t ST_BBM2  = 3'd4;
    localparam state_t ST_DEINT = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level coming from the
// analog side; output is 0 out of reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: times auto-zero and integrate through the external
// phase counter, then counts the de-integrate phase itself.
module dual_slope_ctrl
    import voltmeter_pkg::*;
#(
    parameter int               CNT_W     = VM_CNT_W,
    parameter logic [CNT_W-1:0] T_AZ      = VM_T_AZ,
    parameter logic [CNT_W-1:0] MAX_DEINT = VM_MAX_DEINT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] t_int_i,
    input  logic             cmp_i,
    output logic             cnt_en_o,
    output logic [CNT_W-1:0] cnt_count_o,
    input  logic             cnt_busy_i,
    input  logic             cnt_done_i,
    output logic             sw_zero_o,
    output logic             sw_vin_o,
    output logic             sw_vref_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic             overrange_o,
    output logic [CNT_W-1:0] result_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tint_q, tint_d;
    logic [CNT_W-1:0] deint_cnt_q, deint_cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             ovr_q, ovr_d;
    logic             ld_q, ld_d;
    logic             run_q;
    logic             cmp_s;
    logic             accept;
    logic             deint_max;

    sync_2ff u_cmp_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cmp_i),
        .q_o    (cmp_s)
    );

    // run_q keeps ready_o low while reset is held, so every output reads 0.
    assign accept    = (state_q == ST_IDLE) && run_q && !cnt_busy_i && start_i;
    assign deint_max = (deint_cnt_q == MAX_DEINT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tint_q      <= '0;
            deint_cnt_q <= '0;
            result_q    <= '0;
            ovr_q       <= 1'b0;
            ld_q        <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tint_q      <= tint_d;
            deint_cnt_q <= deint_cnt_d;
            result_q    <= result_d;
            ovr_q       <= ovr_d;
            ld_q        <= ld_d;
            run_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)               state_d = ST_AZ;
            ST_AZ:    if (cnt_done_i)           state_d = ST_BBM1;
            ST_BBM1:                            state_d = ST_INT;
            ST_INT:   if (cnt_done_i)           state_d = ST_BBM2;
            ST_BBM2:                            state_d = ST_DEINT;
            ST_DEINT: if (deint_max || !cmp_s)  state_d = ST_DONE;
            ST_DONE:                            state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
        // Abort wins over every other exit condition.
        if (abort_i && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_comb begin
        tint_d      = accept ? t_int_i : tint_q;
        deint_cnt_d = deint_cnt_q;
        result_d    = result_q;
        ovr_d       = ovr_q;
        ld_d        = (state_d == ST_AZ  && state_q != ST_AZ) ||
                      (state_d == ST_INT && state_q != ST_INT);
        if (state_d == ST_DEINT && state_q != ST_DEINT)
            deint_cnt_d = '0;
        else if (state_q == ST_DEINT && cmp_s && !deint_max)
            deint_cnt_d = deint_cnt_q + CNT_W'(1);
        // Saturated count already equals MAX_DEINT, so it doubles as the result.
        if (state_q == ST_DEINT && state_d == ST_DONE) begin
            result_d = deint_cnt_q;
            ovr_d    = deint_max;
        end
    end

    always_comb begin
        sw_zero_o   = 1'b0;
        sw_vin_o    = 1'b0;
        sw_vref_o   = 1'b0;
        cnt_count_o = '0;
        case (state_q)
            ST_AZ: begin
                sw_zero_o   = 1'b1;
                cnt_count_o = T_AZ;
            end
            ST_INT: begin
                sw_vin_o    = 1'b1;
                cnt_count_o = tint_q;
            end
            ST_DEINT: sw_vref_o = 1'b1;
            default: ;
        endcase
        cnt_en_o    = ld_q;
        ready_o     = (state_q == ST_IDLE) && run_q && !cnt_busy_i;
        busy_o      = (state_q != ST_IDLE);
        valid_o     = (state_q == ST_DONE);
        overrange_o = ovr_q;
        result_o    = result_q;
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Bench for dual_slope_ctrl with a behavioural phase counter; expected results
// are queued at start and compared when valid_o fires.
module tb_dual_slope_ctrl;

    localparam int          W    = 16;
    localparam logic [15:0] TAZ  = 16'd4;
    localparam logic [15:0] MAXD = 16'd50;

    logic          clk;
    logic          rst_n;
    logic          start, abort, cmp;
    logic [W-1:0]  t_int;
    logic          cnt_en, cnt_busy, cnt_done;
    logic [W-1:0]  cnt_count, tc;
    logic          sw_zero, sw_vin, sw_vref, ready, busy, valid, ovr;
    logic [W-1:0]  result;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_overlap = 0;

    dual_slope_ctrl #(.CNT_W(W), .T_AZ(TAZ), .MAX_DEINT(MAXD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .t_int_i     (t_int),
        .cmp_i       (cmp),
        .cnt_en_o    (cnt_en),
        .cnt_count_o (cnt_count),
        .cnt_busy_i  (cnt_busy),
        .cnt_done_i  (cnt_done),
        .sw_zero_o   (sw_zero),
        .sw_vin_o    (sw_vin),
        .sw_vref_o   (sw_vref),
        .ready_o     (ready),
        .busy_o      (busy),
        .valid_o     (valid),
        .overrange_o (ovr),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase counter: load N, done pulse N+1 cycles after the load strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_busy <= 1'b0;
            tc       <= '0;
        end else if (cnt_en) begin
            cnt_busy <= 1'b1;
            tc       <= cnt_count;
        end else if (cnt_busy) begin
            if (tc == 0) cnt_busy <= 1'b0;
            else         tc <= tc - 1'b1;
        end
    end
    assign cnt_done = cnt_busy && (tc == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (32'($countones({sw_zero, sw_vin, sw_vref})) > 1) n_overlap++;
        if (valid) begin
            if (sb_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("overrange", 32'(ovr), 32'(e.ovr));
            end
        end
    end

    task automatic conv_start(input int tint, input logic c);
        int g = 0;
        @(negedge clk);
        while (!ready && g < 2000) begin g++; @(negedge clk); end
        chk("ready_before_start", 32'(ready), 1);
        start = 1'b1; t_int = W'(tint); cmp = c;
        @(negedge clk);
        start = 1'b0;
        chk("az_entry", 32'(sw_zero), 1);
    endtask

    // Entered at the AZ entry cycle; d<0 keeps cmp high to force overrange.
    task automatic conv_body(input int tint, input int d);
        int az = 0, in = 0, dv = 0;
        chk("az_en", 32'(cnt_en), 1);
        chk("az_load", 32'(cnt_count), 32'(TAZ));
        while (sw_zero && az < 1000) begin az++; @(negedge clk); end
        chk("az_len", az, 32'(TAZ) + 2);
        chk("bbm1_open", {29'd0, sw_zero, sw_vin, sw_vref}, 0);
        @(negedge clk);
        chk("int_en", 32'(cnt_en), 1);
        chk("int_load", 32'(cnt_count), tint);
        while (sw_vin && in < 5000) begin in++; @(negedge clk); end
        chk("int_len", in, tint + 2);
        chk("bbm2_open", {29'd0, sw_zero, sw_vin, sw_vref}, 0);
        @(negedge clk);
        chk("deint_sw", 32'(sw_vref), 1);
        if (d >= 2) begin
            repeat (d - 2) @(negedge clk);
            cmp = 1'b0;
            dv  = d - 2;
        end
        while (!valid && dv < 1000) begin dv++; @(negedge clk); end
        chk("valid_latency", dv, (d < 0) ? 32'(MAXD) + 1 : d + 1);
        @(negedge clk);
        cmp = 1'b0;
        chk("valid_one_cycle", 32'(valid), 0);
        chk("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int ign;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmp = 1'b0; t_int = '0;
        #12;
        chk("rst_ctl", {24'd0, cnt_en, sw_zero, sw_vin, sw_vref, ready, busy, valid, ovr}, 0);
        chk("rst_cnt", 32'(cnt_count), 0);
        chk("rst_result", 32'(result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Nominal conversion.
        sb_q.push_back('{res: 16'd37, ovr: 1'b0});
        conv_start(100, 1'b1);
        conv_body(100, 37);

        // Overrange: comparator never falls.
        sb_q.push_back('{res: MAXD, ovr: 1'b1});
        conv_start(20, 1'b1);
        conv_body(20, -1);
        chk("result_hold", 32'(result), 32'(MAXD));

        // Comparator already low on DEINT entry.
        sb_q.push_back('{res: 16'd0, ovr: 1'b0});
        conv_start(10, 1'b0);
        conv_body(10, 0);

        sb_q.push_back('{res: 16'd5, ovr: 1'b0});
        conv_start(7, 1'b1);
        conv_body(7, 5);

        // Abort mid-INT; counter keeps running so start must be refused.
        conv_start(100, 1'b1);
        g = 0;
        while (!sw_vin && g < 100) begin g++; @(negedge clk); end
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'(busy), 0);
        chk("abort_sw_open", {29'd0, sw_zero, sw_vin, sw_vref}, 0);
        chk("abort_no_valid", 32'(valid), 0);
        chk("abort_result_kept", 32'(result), 5);
        start = 1'b1; t_int = 16'd8; cmp = 1'b1;
        g = 0; ign = 0;
        while (cnt_busy && g < 500) begin
            if (busy || ready) ign++;
            g++;
            @(negedge clk);
        end
        chk("start_ignored_while_busy", ign, 0);
        chk("counter_drained", 32'(g > 0 && g < 500), 1);
        sb_q.push_back('{res: 16'd4, ovr: 1'b0});
        @(negedge clk);
        start = 1'b0;
        chk("start_after_drain", 32'(sw_zero), 1);
        conv_body(8, 4);

        // Asynchronous reset in the middle of DEINT.
        conv_start(30, 1'b1);
        g = 0;
        while (!sw_vref && g < 200) begin g++; @(negedge clk); end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {24'd0, cnt_en, sw_zero, sw_vin, sw_vref, ready, busy, valid, ovr}, 0);
        chk("arst_result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{res: 16'd12, ovr: 1'b0});
        conv_start(30, 1'b1);
        conv_body(30, 12);

        repeat (3) @(negedge clk);
        chk("sw_exclusive", n_overlap, 0);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
